// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants and the W-register bundle.
// Used by every stage from fetch through writeback.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'd0;
    localparam logic [3:0] ICODE_NOP  = 4'd1;
    localparam logic [3:0] RNONE      = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valE;
        logic [63:0] valM;
        logic        valid;
    } w_reg_t;

    function automatic w_reg_t w_bubble_val();
        w_reg_t b;
        b.stat  = STAT_AOK;
        b.icode = ICODE_NOP;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.valE  = '0;
        b.valM  = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/writeback_stage_retire_counter.sv
// Free-running retired-instruction counter, wraps modulo 2^32.
module retire_counter
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W register, RUN/STOP control,
// register-write suppression and retired-instruction counting.
module writeback_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic        W_bubble,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_dstE,
    output logic [63:0] W_valE,
    output logic [3:0]  W_dstM,
    output logic [63:0] W_valM,
    output logic        w_stall,
    output logic [2:0]  Stat,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] STOP = 1'b1;

    logic [0:0] r_state;
    w_reg_t     r_w;
    w_reg_t     w_m_entry;
    logic       w_stop;
    logic       w_retire;
    logic       w_ok;
    logic       w_conflict;

    always_comb begin
        w_m_entry.stat  = M_stat;
        w_m_entry.icode = M_icode;
        w_m_entry.dstE  = M_dstE;
        w_m_entry.dstM  = M_dstM;
        w_m_entry.valE  = M_valE;
        w_m_entry.valM  = m_valM;
        w_m_entry.valid = (M_icode != ICODE_NOP);
    end

    assign w_stop = (r_state == STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_w     <= w_bubble_val();
        end else if (!w_stop) begin
            if (W_bubble) begin
                r_w <= w_bubble_val();
            end else begin
                r_w <= w_m_entry;
                if (M_stat != STAT_AOK) begin
                    r_state <= STOP;
                end
            end
        end
    end

    // The entry in W retires on the edge that would replace it.
    assign w_ok     = (r_w.stat == STAT_AOK);
    assign w_retire = !w_stop && r_w.valid && w_ok;

    retire_counter u_retire (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_retire),
        .o_count (retired)
    );

    // Same destination on both ports: the M port wins.
    assign w_conflict = (r_w.dstE == r_w.dstM) && (r_w.dstE != RNONE);

    assign W_stat  = r_w.stat;
    assign W_icode = r_w.icode;
    assign W_dstE  = (!w_ok || w_conflict) ? RNONE : r_w.dstE;
    assign W_dstM  = !w_ok ? RNONE : r_w.dstM;
    assign W_valE  = r_w.valE;
    assign W_valM  = r_w.valM;
    assign Stat    = r_w.stat;
    assign w_stall = w_stop;
    assign halted  = w_stop;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus
// halt, fault, reset and counter-wrap sequences.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic        W_bubble;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [63:0] W_valE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valM;
    logic        w_stall;
    logic [2:0]  Stat;
    logic        halted;
    logic [31:0] retired;

    int n_cmp;
    int n_err;

    writeback_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .M_stat   (M_stat),
        .M_icode  (M_icode),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .M_valE   (M_valE),
        .m_valM   (m_valM),
        .W_bubble (W_bubble),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .w_stall  (w_stall),
        .Stat     (Stat),
        .halted   (halted),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic [2:0] s,
                         input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve,
                         input logic [63:0] vm);
        W_bubble = b;
        M_stat   = s;
        M_icode  = ic;
        M_dstE   = de;
        M_dstM   = dm;
        M_valE   = ve;
        m_valM   = vm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".Stat"}, 64'(Stat), 64'd1);
        check({tag, ".halted"}, 64'(halted), 64'd0);
        check({tag, ".w_stall"}, 64'(w_stall), 64'd0);
        check({tag, ".W_dstE"}, 64'(W_dstE), 64'd15);
        check({tag, ".W_dstM"}, 64'(W_dstM), 64'd15);
        check({tag, ".W_icode"}, 64'(W_icode), 64'd1);
        check({tag, ".retired"}, 64'(retired), 64'd0);
    endtask

    typedef struct {
        logic        b;
        logic [2:0]  s;
        logic [3:0]  ic;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [2:0]  x_stat;
        logic [3:0]  x_icode;
        logic [3:0]  x_dstE;
        logic [3:0]  x_dstM;
        logic [63:0] x_valE;
        logic [63:0] x_valM;
        logic [31:0] x_ret;
    } vec_t;

    vec_t vecs[7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 3'd1, 4'd1, 4'd15, 4'd15, 64'd0, 64'd0);

        //      b  s  ic de dm valE      valM      stat ic de dm valE     valM    ret
        vecs[0] = '{0, 1, 2, 3, 15, 64'h55,   64'h0,    1, 2, 3, 15, 64'h55,  64'h0,    0};
        vecs[1] = '{0, 1, 11, 4, 4, 64'h20,   64'h10,   1, 11, 15, 4, 64'h20, 64'h10,   1};
        vecs[2] = '{1, 1, 6, 2, 15, 64'h77,   64'h99,   1, 1, 15, 15, 64'h0,  64'h0,    2};
        vecs[3] = '{0, 1, 1, 15, 15, 64'h0,   64'h0,    1, 1, 15, 15, 64'h0,  64'h0,    2};
        vecs[4] = '{0, 1, 6, 7, 15, 64'hABCD, 64'h0,    1, 6, 7, 15, 64'hABCD, 64'h0,   2};
        vecs[5] = '{0, 1, 5, 15, 8, 64'h100,  64'hDEAD, 1, 5, 15, 8, 64'h100, 64'hDEAD, 3};
        vecs[6] = '{1, 1, 2, 2, 2, 64'h1,     64'h2,    1, 1, 15, 15, 64'h0,  64'h0,    4};

        #12;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].b, vecs[i].s, vecs[i].ic, vecs[i].de,
                  vecs[i].dm, vecs[i].ve, vecs[i].vm);
            tick();
            check($sformatf("v%0d.Stat", i), 64'(Stat), 64'(vecs[i].x_stat));
            check($sformatf("v%0d.W_icode", i), 64'(W_icode), 64'(vecs[i].x_icode));
            check($sformatf("v%0d.W_dstE", i), 64'(W_dstE), 64'(vecs[i].x_dstE));
            check($sformatf("v%0d.W_dstM", i), 64'(W_dstM), 64'(vecs[i].x_dstM));
            check($sformatf("v%0d.W_valE", i), W_valE, vecs[i].x_valE);
            check($sformatf("v%0d.W_valM", i), W_valM, vecs[i].x_valM);
            check($sformatf("v%0d.retired", i), 64'(retired), 64'(vecs[i].x_ret));
            check($sformatf("v%0d.w_stall", i), 64'(w_stall), 64'd0);
        end

        // Halt: freezes W and the counter
        drive(1'b0, 3'd2, 4'd0, 4'd15, 4'd15, 64'h0, 64'h0);
        tick();
        check("halt.Stat", 64'(Stat), 64'd2);
        check("halt.halted", 64'(halted), 64'd1);
        check("halt.w_stall", 64'(w_stall), 64'd1);
        check("halt.W_icode", 64'(W_icode), 64'd0);
        check("halt.retired", 64'(retired), 64'd4);
        for (int k = 0; k < 5; k++) begin
            drive(k[0], 3'd1, 4'(k + 2), 4'(k), 4'(k + 1),
                  64'(k * 17 + 3), 64'(k * 5 + 9));
            tick();
            check($sformatf("hold%0d.W_stat", k), 64'(W_stat), 64'd2);
            check($sformatf("hold%0d.W_icode", k), 64'(W_icode), 64'd0);
            check($sformatf("hold%0d.W_valE", k), W_valE, 64'd0);
            check($sformatf("hold%0d.retired", k), 64'(retired), 64'd4);
            check($sformatf("hold%0d.halted", k), 64'(halted), 64'd1);
        end

        // Reset mid-cycle while stopped, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_stop");
        @(negedge clk);
        rst_n = 1'b1;

        // Fault: write suppressed, then mid-cycle reset
        drive(1'b0, 3'd3, 4'd5, 4'd15, 4'd5, 64'h40, 64'h41);
        tick();
        check("fault.Stat", 64'(Stat), 64'd3);
        check("fault.W_dstM", 64'(W_dstM), 64'd15);
        check("fault.W_valM", W_valM, 64'h41);
        check("fault.halted", 64'(halted), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("frst.Stat", 64'(Stat), 64'd1);
        check("frst.halted", 64'(halted), 64'd0);
        check("frst.w_stall", 64'(w_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First load after reset release, plus counter wrap
        drive(1'b0, 3'd1, 4'd2, 4'd9, 4'd15, 64'h1234, 64'h0);
        #1;
        force dut.u_retire.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire.r_count;
        tick();
        check("first.W_dstE", 64'(W_dstE), 64'd9);
        check("wrap.pre", 64'(retired), 64'hFFFF_FFFF);
        drive(1'b1, 3'd1, 4'd2, 4'd9, 4'd15, 64'h0, 64'h0);
        tick();
        check("wrap.post", 64'(retired), 64'd0);
        check("wrap.W_icode", 64'(W_icode), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL provide: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: M_stat  in  3; M_icode  in  4; M_dstE  in  4; M_dstM  in  4; M_valE  in  64; m_valM  in  64 (memory-stage results).
REQ-004 SHALL provide: W_bubble  in  1  load a bubble into the W register instead of M-stage values.
REQ-005 SHALL provide: W_stat  out  3; W_icode  out  4 (W register contents).
REQ-006 SHALL provide: W_dstE  out  4; W_valE  out  64; W_dstM  out  4; W_valM  out  64 (register-file write ports and decode forwarding sources).
REQ-007 SHALL provide: w_stall  out  1  W register frozen; routed to the hazard unit.
REQ-008 SHALL provide: Stat  out  3; halted  out  1; retired  out  32  (retired-instruction count).

Function
REQ-009 SHALL use codes AOK=1, HLT=2, ADR=3, INS=4; NOP icode=1; RNONE=15.
REQ-010 SHALL implement a 2-state FSM: RUN and STOP.
REQ-011 In RUN, SHALL load the W register on each rising edge: M values if W_bubble=0, bubble values otherwise.
REQ-012 Bubble values SHALL be: stat AOK, icode NOP, both dst RNONE, both val 0, valid=0.
REQ-013 An M load SHALL set valid=1 unless M_icode=NOP.
REQ-014 RUN->STOP SHALL occur on the edge that loads an M entry with M_stat != AOK.
REQ-015 In STOP, the W register SHALL hold its value and ignore W_bubble.
REQ-016 STOP SHALL be left only through reset.
REQ-017 w_stall and halted SHALL both equal (state==STOP).
REQ-018 Stat SHALL equal the W register stat, combinationally.
REQ-019 Write suppression: if W stat != AOK, W_dstE and W_dstM outputs SHALL read RNONE.
REQ-020 Consequence of REQ-019: a faulting or halting instruction never writes registers and is never forwarded.
REQ-021 Same-register conflict: if W dstE == W dstM != RNONE, W_dstE output SHALL read RNONE, so the M-port value wins (popq %rsp semantics).
REQ-022 W_valE and W_valM SHALL always present the W register values unmodified.
REQ-023 retired SHALL increment by 1 on each rising edge where state==RUN, valid=1 and W stat==AOK.
REQ-024 retired SHALL wrap modulo 2^32.
REQ-025 The STOP-triggering instruction SHALL NOT be counted; retired SHALL be frozen in STOP.
REQ-026 Latency: M inputs SHALL appear on W outputs one clock after capture; there is no combinational path from M inputs to outputs.

Reset
REQ-027 On rst_n=0, the W register SHALL take bubble values immediately, regardless of clk.
REQ-028 On rst_n=0, state SHALL be RUN and retired SHALL be 0, immediately, regardless of clk.
REQ-029 Reset asserted mid-operation, including in STOP, SHALL abandon the held entry.
REQ-030 Resulting output values under reset: Stat=1, W_dstE=W_dstM=15, w_stall=0, halted=0.
REQ-031 The first load SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-032 Stat codes, icode constants and RNONE SHALL live in shared package y86_pkg, also used by fetch, decode, execute and memory.
REQ-033 FSM state encoding SHALL be local to the module.
REQ-034 No sub-module is required; the retire counter MAY be split out as retire_counter.

Verification
REQ-035 Normal write: M_stat=1, M_icode=2, M_dstE=3, M_valE=0x55, W_bubble=0 -> next cycle W_dstE=3, W_valE=0x55, Stat=1, retired 0->1 on the following edge.
REQ-036 Conflict: M_icode=11, M_dstE=4, M_dstM=4, m_valM=0x10 -> W_dstE=15, W_dstM=4, W_valM=0x10.
REQ-037 Halt: M_stat=2, M_icode=0 -> Stat=2, halted=1, w_stall=1; then 5 more cycles of varied M inputs -> W outputs unchanged and retired unchanged.
REQ-038 Fault: M_stat=3, M_dstM=5 -> W_dstM=15, Stat=3; then pulse rst_n low mid-cycle -> Stat=1, halted=0 without a clock edge.
REQ-039 Bubble: W_bubble=1 with M_dstE=2 -> W_dstE=15, W_icode=1, retired unchanged.
REQ-040 Wrap: preload retired to 0xFFFFFFFF, retire one AOK instruction -> retired=0.
